// File: rtl/tri_arb_pkg.sv
// Shared types and constants for the tristate bus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: FSM state encoding, default parameter values, and a one-hot to
// index helper sized for the largest supported requester count.
package tri_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } arb_state_t;

  localparam int DEF_N_REQ    = 4;
  localparam int DEF_WIDTH    = 8;
  localparam int DEF_MAX_HOLD = 16;
  localparam int DEF_TURN_CYC = 1;

  // Largest requester count; the helper below works on this width.
  localparam int MAX_REQ = 8;

  // Index of the set bit in a one-hot vector (0 when the vector is all zero).
  function automatic logic [2:0] oh_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/tri_bus_arbiter_rr_pick.sv
// Round-robin requester selection, purely combinational.
// Latency: 0 cycles (pick follows req/last_owner in the same cycle).
// Backpressure: none; the caller decides when to use the pick.
//
// Ports:
//   req        - per-requester request vector
//   last_owner - index of the most recent owner; search starts just above it
//   pick       - one-hot winner, all zero when req is all zero
module rr_pick
  import tri_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int IDXW  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDXW-1:0]  last_owner,
  output logic [N_REQ-1:0] pick
);

  // Rotation amount: last_owner+1, which may equal N_REQ (full rotation).
  logic [IDXW:0]      w_shamt;
  logic [N_REQ-1:0]   w_rot;
  logic [N_REQ-1:0]   w_first;

  assign w_shamt = {1'b0, last_owner} + (IDXW + 1)'(1);

  // Rotate req right so bit 0 is the requester just above last_owner; the
  // doubled vector makes the shift behave as a rotate.
  assign w_rot = N_REQ'({req, req} >> w_shamt);

  // Isolate the lowest set bit of the rotated vector.
  assign w_first = w_rot & (~w_rot + N_REQ'(1));

  // Rotate the winner back into original requester positions.
  assign pick = N_REQ'(({w_first, w_first} << w_shamt) >> N_REQ);

endmodule

// File: rtl/tri_bus_arbiter.sv
// Tristate bus arbiter: round-robin ownership of a shared bus with hold limit and float turnaround.
// Latency: grant 1 cycle after request seen in IDLE; release 1 cycle after owner request drops or hold limit.
// Backpressure: requests are level-held; waiting requesters simply keep req high until granted.
//
// Ports:
//   clk, rst_n - clock, synchronous active-low reset
//   req        - per-requester bus request (level)
//   wdata      - per-requester drive data, requester i at [i*WIDTH +: WIDTH]
//   bus_io     - shared tristate bus, driven only while drv_en is high
//   gnt        - registered one-hot grant (or zero)
//   drv_en     - registered, high exactly when this block drives bus_io
//   rdata      - bus_io sampled at the previous edge
//   busy       - high in GRANT or TURN
module tri_bus_arbiter
  import tri_arb_pkg::*;
#(
  parameter int N_REQ    = DEF_N_REQ,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int MAX_HOLD = DEF_MAX_HOLD,
  parameter int TURN_CYC = DEF_TURN_CYC
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   wdata,
  inout  wire  [WIDTH-1:0]         bus_io,
  output logic [N_REQ-1:0]         gnt,
  output logic                     drv_en,
  output logic [WIDTH-1:0]         rdata,
  output logic                     busy
);

  localparam int IDXW   = $clog2(N_REQ);
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam int TURN_W = $clog2(TURN_CYC + 1);

  // Hold counter starts at 0 on the first grant cycle, so the last permitted
  // grant cycle is the one where it reads MAX_HOLD-1.
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURN_CYC - 1);

  // State registers
  arb_state_t         r_state;
  logic [N_REQ-1:0]   r_gnt;
  logic               r_drv_en;
  logic [IDXW-1:0]    r_owner;
  logic [IDXW-1:0]    r_last_owner;
  logic [HOLD_W-1:0]  r_hold;
  logic [TURN_W-1:0]  r_turn;
  logic [WIDTH-1:0]   r_rdata;

  // Next-state values
  arb_state_t         w_state_nxt;
  logic [N_REQ-1:0]   w_gnt_nxt;
  logic [IDXW-1:0]    w_owner_nxt;
  logic [IDXW-1:0]    w_last_nxt;
  logic [HOLD_W-1:0]  w_hold_nxt;
  logic [TURN_W-1:0]  w_turn_nxt;

  logic [N_REQ-1:0]   w_pick;
  logic [IDXW-1:0]    w_pick_idx;
  logic               w_owner_req;
  logic [WIDTH-1:0]   w_drv_dat;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDXW  (IDXW)
  ) u_rr_pick (
    .req        (req),
    .last_owner (r_last_owner),
    .pick       (w_pick)
  );

  assign w_pick_idx  = IDXW'(oh_to_idx(MAX_REQ'(w_pick)));

  // Only the current owner's request matters during GRANT; other requesters
  // changing their req have no effect until the next IDLE selection.
  assign w_owner_req = |(req & r_gnt);

  // Select the owner's data slice by shifting the packed data vector down.
  assign w_drv_dat = WIDTH'(wdata >> (int'(r_owner) * WIDTH));

  // Single driver of the shared bus; floats whenever no grant is active.
  assign bus_io = r_drv_en ? w_drv_dat : {WIDTH{1'bz}};

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last_owner;
    w_hold_nxt  = r_hold;
    w_turn_nxt  = r_turn;

    case (r_state)
      ST_IDLE: begin
        w_gnt_nxt = '0;
        if (|req) begin
          w_state_nxt = ST_GRANT;
          w_gnt_nxt   = w_pick;
          w_owner_nxt = w_pick_idx;
          w_hold_nxt  = '0;
        end
      end

      ST_GRANT: begin
        if (!w_owner_req || (r_hold == HOLD_LAST)) begin
          // Recording the outgoing owner as last_owner makes it the lowest
          // priority at the next selection, which gives the preemption
          // fairness for free.
          w_state_nxt = ST_TURN;
          w_gnt_nxt   = '0;
          w_last_nxt  = r_owner;
          w_turn_nxt  = '0;
        end else begin
          w_hold_nxt = r_hold + HOLD_W'(1);
        end
      end

      ST_TURN: begin
        w_gnt_nxt = '0;
        if (r_turn == TURN_LAST) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_turn_nxt = r_turn + TURN_W'(1);
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_gnt        <= '0;
      r_drv_en     <= 1'b0;
      r_owner      <= '0;
      r_last_owner <= IDXW'(N_REQ - 1);
      r_hold       <= '0;
      r_turn       <= '0;
      r_rdata      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_gnt        <= w_gnt_nxt;
      r_drv_en     <= |w_gnt_nxt;
      r_owner      <= w_owner_nxt;
      r_last_owner <= w_last_nxt;
      r_hold       <= w_hold_nxt;
      r_turn       <= w_turn_nxt;
      r_rdata      <= bus_io;
    end
  end

  assign gnt    = r_gnt;
  assign drv_en = r_drv_en;
  assign rdata  = r_rdata;
  assign busy   = (r_state == ST_GRANT) || (r_state == ST_TURN);

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Bench for tri_bus_arbiter: directed request patterns, ownership scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_tri_bus_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MH = 16;
  localparam int TC = 1;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req   = '0;
  logic [N*W-1:0] wdata = '0;
  wire  [W-1:0]   bus_io;
  logic [N-1:0]   gnt;
  logic           drv_en;
  logic [W-1:0]   rdata;
  logic           busy;

  tri_bus_arbiter #(
    .N_REQ    (N),
    .WIDTH    (W),
    .MAX_HOLD (MH),
    .TURN_CYC (TC)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .wdata  (wdata),
    .bus_io (bus_io),
    .gnt    (gnt),
    .drv_en (drv_en),
    .rdata  (rdata),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // High in the cycle following an edge at which reset was applied.
  logic rst_seen = 1'b0;
  always @(posedge clk) rst_seen <= !rst_n;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  typedef struct {
    int owner;
    int start;
    int len;
  } own_t;

  own_t exp_q[$];

  task automatic expect_own(input int o, input int s, input int l);
    own_t e;
    e.owner = o;
    e.start = s;
    e.len   = l;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      wdata = $urandom();
    end
  endtask

  function automatic int oh_idx(input logic [N-1:0] g);
    int r;
    r = 0;
    for (int i = 0; i < N; i++) if (g[i]) r = i;
    return r;
  endfunction

  // Monitor: per-cycle invariants plus ownership reconstruction against the queue.
  bit         cur_act  = 1'b0;
  int         cur_owner, cur_start, cur_len, end_cyc;
  bit         have_prev = 1'b0;
  bit         prev_drv  = 1'b0;
  logic [W-1:0] prev_bus;

  always @(negedge clk) begin : mon
    int   o;
    logic eb;
    own_t e;
    if (cyc > 0) begin
      chk("onehot0_gnt", 32'($onehot0(gnt)), 32'd1);
      chk("drv_en_eq_or_gnt", 32'(drv_en), 32'(|gnt));

      if (rst_seen) begin
        chk("reset_gnt", 32'(gnt), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_rdata", 32'(rdata), 32'd0);
      end else if (prev_drv) begin
        chk("rdata_prev_bus", 32'(rdata), 32'(prev_bus));
      end

      if (drv_en) begin
        o = oh_idx(gnt);
        chk("bus_owner_data", 32'(bus_io), 32'(W'(wdata >> (o * W))));
      end

      if (gnt != '0) begin
        o = oh_idx(gnt);
        if (!cur_act) begin
          if (have_prev) chk("float_gap_min", 32'((cyc - end_cyc) >= TC + 1), 32'd1);
          cur_act   = 1'b1;
          cur_owner = o;
          cur_start = cyc;
          cur_len   = 1;
        end else begin
          chk("owner_stable", 32'(o), 32'(cur_owner));
          cur_len++;
        end
      end else if (cur_act) begin
        cur_act   = 1'b0;
        end_cyc   = cyc;
        have_prev = 1'b1;
        chk("ownership_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("own_owner", 32'(cur_owner), 32'(e.owner));
          chk("own_start", 32'(cur_start), 32'(e.start));
          chk("own_len", 32'(cur_len), 32'(e.len));
        end
      end

      if (rst_seen) have_prev = 1'b0;

      if (!rst_seen) begin
        eb = (gnt != '0) || (have_prev && !cur_act && ((cyc - end_cyc) < TC));
        chk("busy", 32'(busy), 32'(eb));
      end

      prev_drv = drv_en;
      prev_bus = bus_io;
    end
  end

  initial begin : stim
    int c;
    wdata = $urandom();
    step(3);

    // Single requester straight out of reset: grant one cycle later, 3 cycles.
    c = cyc; rst_n = 1'b1; req = 4'b0001;
    expect_own(0, c + 1, 3);
    step(3); req = 4'b0000;
    step(4);

    // All requesting from reset: 0,1,2,3,0 each 16 cycles, 18-cycle pitch.
    rst_n = 1'b0; step(2);
    c = cyc; rst_n = 1'b1; req = 4'b1111;
    expect_own(0, c + 1, 16);
    expect_own(1, c + 19, 16);
    expect_own(2, c + 37, 16);
    expect_own(3, c + 55, 16);
    expect_own(0, c + 73, 16);
    step(89); req = 4'b0000;
    step(4);

    // Owner 2 drops after 3 cycles while others join; then 0 (3 cycles), 1 (1 cycle).
    c = cyc; req = 4'b0100;
    expect_own(2, c + 1, 3);
    expect_own(0, c + 6, 3);
    expect_own(1, c + 11, 1);
    step(1); req = 4'b0111;
    step(2); req = 4'b0011;
    step(5); req = 4'b0010;
    step(3); req = 4'b0000;
    step(4);

    // Lone requester 1: regranted after each full hold plus 2-cycle gap.
    c = cyc; req = 4'b0010;
    expect_own(1, c + 1, 16);
    expect_own(1, c + 19, 16);
    expect_own(1, c + 37, 16);
    step(53); req = 4'b0000;
    step(4);

    // Reset mid-grant releases next edge; afterwards 1010 picks requester 1.
    c = cyc; req = 4'b0100;
    expect_own(2, c + 1, 4);
    step(4); rst_n = 1'b0;
    step(2); rst_n = 1'b1; req = 4'b1010;
    expect_own(1, c + 7, 5);
    step(5); req = 4'b0000;
    step(6);

    chk("pending_ownerships", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tri_bus_arbiter.md
TRI_BUS_ARBITER -- requirements
Module: tri_bus_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters sharing the tristate bus (2..8).
REQ-002 SHALL have parameter WIDTH, default 8, tristate bus width in bits.
REQ-003 SHALL have parameter MAX_HOLD, default 16, maximum consecutive grant cycles per ownership (>=1).
REQ-004 SHALL have parameter TURN_CYC, default 1, bus-float turnaround cycles between owners (>=1).
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port req  input  N_REQ  per-requester bus request, level-sensitive.
REQ-008 SHALL have port wdata  input  N_REQ*WIDTH  per-requester drive data, requester i at bits [i*WIDTH +: WIDTH].
REQ-009 SHALL have port bus_io  inout  WIDTH  shared tristate bus.
REQ-010 SHALL have port gnt  output  N_REQ  registered one-hot grant, or all zero.
REQ-011 SHALL have port drv_en  output  1  registered; high exactly when this block drives bus_io.
REQ-012 SHALL have port rdata  output  WIDTH  bus_io registered each cycle.
REQ-013 SHALL have port busy  output  1  high in GRANT or TURN states.

Function
REQ-014 SHALL implement three states: IDLE, GRANT, TURN.
REQ-015 SHALL drive bus_io = wdata[owner] when drv_en=1, else all bits 'z; no other driver inside the block.
REQ-016 SHALL keep gnt one-hot or zero at all times; drv_en = |gnt.
REQ-017 IDLE: if req!=0, SHALL select the first set req bit searching from last_owner+1 upward with wrap, and assert gnt/drv_en on the next cycle (latency 1), entering GRANT.
REQ-018 IDLE with req==0: SHALL remain IDLE; gnt=0, drv_en=0.
REQ-019 GRANT: SHALL keep the grant while req[owner]=1 and the hold count is below MAX_HOLD.
REQ-020 GRANT: SHALL deassert gnt/drv_en the cycle after req[owner] falls, entering TURN.
REQ-021 GRANT: SHALL release after exactly MAX_HOLD grant cycles even if req[owner] remains high, entering TURN.
REQ-022 TURN: SHALL hold gnt=0, drv_en=0, bus floating, for exactly TURN_CYC cycles, then enter IDLE.
REQ-023 Consecutive ownerships SHALL therefore be separated by exactly TURN_CYC+1 non-driving cycles when requests are pending.
REQ-024 A requester preempted by MAX_HOLD and still requesting SHALL become lowest priority; it is regranted only if no other req is set.
REQ-025 Req changes of non-owners during GRANT/TURN SHALL not affect the current ownership.
REQ-026 rdata SHALL equal bus_io sampled at the previous edge, including X/Z when floating.
REQ-027 The hold counter SHALL be sized $clog2(MAX_HOLD+1) and clear on entry to GRANT.

Reset
REQ-028 On rst_n=0 at a clock edge: state=IDLE, gnt=0, drv_en=0, busy=0, rdata=0, hold count=0, last_owner=N_REQ-1 (requester 0 highest priority first).
REQ-029 Reset asserted during GRANT SHALL release the bus on the following edge, no turnaround required.

Structure
REQ-030 State enum and default parameter constants SHALL reside in package tri_arb_pkg.
REQ-031 Round-robin selection SHALL be a combinational sub-module rr_pick (inputs req, last_owner; output one-hot pick).

Verification
REQ-032 Reset, req=4'b0001 at cycle 0 -> gnt=0001, drv_en=1 at cycle 1; bus_io=wdata[0].
REQ-033 req=4'b1111 held, MAX_HOLD=16, TURN_CYC=1 -> grants 0,1,2,3,0 in order, each 16 cycles, 2 float cycles between.
REQ-034 Owner 2 drops req after 3 grant cycles -> gnt=0 next cycle, bus_io=zzzzzzzz for 1 TURN cycle plus 1 IDLE cycle.
REQ-035 Only req[1] held continuously -> regranted to 1 after each 16-cycle hold plus 2-cycle gap.
REQ-036 rst_n=0 mid-GRANT -> gnt=0, drv_en=0, bus floating next cycle; after release, req=1010 -> requester 1 granted.
REQ-037 Every cycle assert $onehot0(gnt) and drv_en==|gnt; no two grants without >=TURN_CYC+1 gap.
